uart_transceiver: RTL and testbench



---
 rtl/uart_transceiver.sv | 203 ++++++++++++++++++++
 tb/tb_uart_transceiver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: TX serialises a byte on an accepted start, RX deserialises rx via a 2-flop sync.
// TX start bit appears the cycle after acceptance; start outside IDLE is ignored (no queueing, no abort).
`timescale 1ns/1ps
module uart_transceiver #(
  parameter int clk_freq  = 50000000,
  parameter int baud_rate = 19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [7:0] tx_data_in,
  input  logic       start,
  output logic [7:0] rx_data_out,
  output logic       tx,
  output logic       tx_active,
  output logic       done_tx
);

  localparam int CPB  = clk_freq / baud_rate;
  localparam int HALF = (CPB / 2 > 0) ? CPB / 2 : 1;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE
  } tx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_q, tx_d;
  logic            tx_active_q, tx_active_d;
  logic            done_tx_q, done_tx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_byte_q   <= 8'h00;
      tx_q        <= 1'b1;
      tx_active_q <= 1'b0;
      done_tx_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_byte_q   <= tx_byte_d;
      tx_q        <= tx_d;
      tx_active_q <= tx_active_d;
      done_tx_q   <= done_tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (start) begin
          tx_byte_d  = tx_data_in;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DONE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DONE: tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase

    // Outputs decoded from the next state so the pin comes straight off a flop.
    tx_d        = 1'b1;
    tx_active_d = 1'b0;
    done_tx_d   = 1'b0;
    case (tx_state_d)
      TX_START: begin tx_d = 1'b0;                  tx_active_d = 1'b1; end
      TX_DATA:  begin tx_d = tx_byte_d[tx_bit_d];   tx_active_d = 1'b1; end
      TX_STOP:  begin tx_d = 1'b1;                  tx_active_d = 1'b1; end
      TX_DONE:  done_tx_d = 1'b1;
      default:  ;
    endcase
  end

  assign tx        = tx_q;
  assign tx_active = tx_active_q;
  assign done_tx   = done_tx_q;

  // ---------------------------------------------------------------- RX
  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

  logic [1:0]    rx_sync_q;
  logic          rx_s;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;

  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rx};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Half a bit in: a start bit that is no longer low was a glitch.
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          if (!rx_s) begin
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          if (rx_s) rx_data_d = rx_shift_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign rx_data_out = rx_data_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Randomised bench for uart_transceiver with a frame-level reference model (bit k of a frame from the byte).
`timescale 1ns/1ps
module tb_uart_transceiver;

  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic       rx;
  logic [7:0] rx_data_out;
  logic       tx;
  logic       tx_active;
  logic       done_tx;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] last_rx;

  assign rx = loop_en ? tx : rx_drv;

  uart_transceiver #(.clk_freq(CLK_FREQ), .baud_rate(BAUD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx_data_in(tx_data_in), .start(start),
    .rx_data_out(rx_data_out), .tx(tx), .tx_active(tx_active), .done_tx(done_tx)
  );

  always #5 clk = ~clk;

  // Line level of frame bit k: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic kick(input logic [7:0] b, input bit hold);
    @(negedge clk);
    tx_data_in = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Observe cycles 1..FRAME+1 after the accepting edge against the reference frame.
  task automatic watch_tx(input logic [7:0] b, output int bad_tx, output int bad_act,
                          output int bad_done, output int first_bad);
    logic e;
    bad_tx = 0; bad_act = 0; bad_done = 0; first_bad = -1;
    for (int i = 1; i <= FRAME + 1; i++) begin
      @(negedge clk);
      e = (i <= FRAME) ? frame_bit(b, (i - 1) / CPB) : 1'b1;
      if (tx !== e) begin
        bad_tx++;
        if (first_bad < 0) first_bad = i;
      end
      if (tx_active !== (i <= FRAME)) bad_act++;
      if (done_tx !== (i == FRAME + 1)) bad_done++;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_val);
    for (int k = 0; k < 10; k++) begin
      rx_drv = (k == 9) ? stop_val : frame_bit(b, k);
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++; if (tx_active !== 1'b0) begin n_fail++; $display("FAIL reset_tx_active: got %b expected 0", tx_active); end
    n_checks++; if (done_tx !== 1'b0) begin n_fail++; $display("FAIL reset_done_tx: got %b expected 0", done_tx); end
    n_checks++; if (rx_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data_out); end
    last_rx = 8'h00;
  endtask

  task automatic test_loopback();
    logic [7:0] b;
    int bt, ba, bd, fb;
    loop_en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      b = (j == 0) ? 8'hA5 : 8'($urandom);
      kick(b, 1'b0);
      watch_tx(b, bt, ba, bd, fb);
      n_checks++; if (bt !== 0) begin n_fail++; $display("FAIL loop_tx_wave byte %h: %0d bad cycles (first %0d) expected 0", b, bt, fb); end
      n_checks++; if (ba !== 0) begin n_fail++; $display("FAIL loop_tx_active byte %h: %0d bad cycles expected 0", b, ba); end
      n_checks++; if (bd !== 0) begin n_fail++; $display("FAIL loop_done_tx byte %h: %0d bad cycles expected 0", b, bd); end
      n_checks++; if (rx_data_out !== b) begin n_fail++; $display("FAIL loop_rx_data: got %h expected %h", rx_data_out, b); end
      last_rx = b;
    end
  endtask

  task automatic test_back_to_back();
    int bt, ba, bd, fb;
    loop_en = 1'b1;
    kick(8'h00, 1'b1);
    tx_data_in = 8'hFF;
    watch_tx(8'h00, bt, ba, bd, fb);
    n_checks++; if (bt + ba + bd !== 0) begin n_fail++; $display("FAIL b2b_frame0: %0d/%0d/%0d bad cycles (first %0d) expected 0", bt, ba, bd, fb); end
    n_checks++; if (rx_data_out !== 8'h00) begin n_fail++; $display("FAIL b2b_rx0: got %h expected 00", rx_data_out); end
    @(negedge clk);
    n_checks++; if ({tx, tx_active} !== 2'b10) begin n_fail++; $display("FAIL b2b_gap: got tx=%b act=%b expected tx=1 act=0", tx, tx_active); end
    watch_tx(8'hFF, bt, ba, bd, fb);
    start = 1'b0;
    n_checks++; if (bt + ba + bd !== 0) begin n_fail++; $display("FAIL b2b_frame1: %0d/%0d/%0d bad cycles (first %0d) expected 0", bt, ba, bd, fb); end
    n_checks++; if (rx_data_out !== 8'hFF) begin n_fail++; $display("FAIL b2b_rx1: got %h expected ff", rx_data_out); end
    last_rx = 8'hFF;
  endtask

  task automatic test_ignore_start();
    int bt, ba, bd, fb, extra;
    loop_en = 1'b1;
    kick(8'h81, 1'b0);
    fork
      watch_tx(8'h81, bt, ba, bd, fb);
      begin
        repeat (5 * CPB) @(negedge clk);
        tx_data_in = 8'h3C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    n_checks++; if (bt + ba + bd !== 0) begin n_fail++; $display("FAIL ignore_frame: %0d/%0d/%0d bad cycles (first %0d) expected 0", bt, ba, bd, fb); end
    n_checks++; if (rx_data_out !== 8'h81) begin n_fail++; $display("FAIL ignore_rx: got %h expected 81", rx_data_out); end
    extra = 0;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_active !== 1'b0 || done_tx !== 1'b0) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignore_no_second_frame: %0d active cycles expected 0", extra); end
    last_rx = 8'h81;
  endtask

  task automatic test_rx_errors();
    logic [7:0] b;
    loop_en = 1'b0;
    rx_drv = 1'b1;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    n_checks++; if (rx_data_out !== last_rx) begin n_fail++; $display("FAIL rx_glitch: got %h expected %h", rx_data_out, last_rx); end
    b = 8'($urandom);
    send_rx(b, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (rx_data_out !== last_rx) begin n_fail++; $display("FAIL rx_framing: got %h expected %h", rx_data_out, last_rx); end
    rx_drv = 1'b0;
    repeat (25 * CPB) @(negedge clk);
    n_checks++; if (rx_data_out !== last_rx) begin n_fail++; $display("FAIL rx_held_low: got %h expected %h", rx_data_out, last_rx); end
    rx_drv = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    b = 8'($urandom);
    send_rx(b, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++; if (rx_data_out !== b) begin n_fail++; $display("FAIL rx_rearm: got %h expected %h", rx_data_out, b); end
    last_rx = b;
  endtask

  task automatic test_full_duplex();
    logic [7:0] bt_byte, br_byte;
    int bt, ba, bd, fb;
    loop_en = 1'b0;
    bt_byte = 8'($urandom);
    br_byte = 8'($urandom);
    fork
      begin
        kick(bt_byte, 1'b0);
        watch_tx(bt_byte, bt, ba, bd, fb);
      end
      begin
        @(negedge clk);
        send_rx(br_byte, 1'b1);
      end
    join
    repeat (4) @(negedge clk);
    n_checks++; if (bt + ba + bd !== 0) begin n_fail++; $display("FAIL duplex_tx: %0d/%0d/%0d bad cycles (first %0d) expected 0", bt, ba, bd, fb); end
    n_checks++; if (rx_data_out !== br_byte) begin n_fail++; $display("FAIL duplex_rx: got %h expected %h", rx_data_out, br_byte); end
    last_rx = br_byte;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int bad, pulses, bt, ba, bd, fb;
    loop_en = 1'b1;
    b = 8'($urandom);
    kick(b, 1'b0);
    repeat (5 * CPB + CPB / 2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b expected 1", tx); end
    n_checks++; if (tx_active !== 1'b0) begin n_fail++; $display("FAIL midrst_tx_active: got %b expected 0", tx_active); end
    n_checks++; if (rx_data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_data: got %h expected 00", rx_data_out); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0; pulses = 0;
    for (int i = 0; i < 12 * CPB; i++) begin
      @(negedge clk);
      if (done_tx === 1'b1) pulses++;
      if (tx !== 1'b1 || tx_active !== 1'b0) bad++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_done_pulses: got %0d expected 0", pulses); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midrst_idle_line: %0d active cycles expected 0", bad); end
    n_checks++; if (rx_data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_discard: got %h expected 00", rx_data_out); end
    b = 8'($urandom);
    kick(b, 1'b0);
    watch_tx(b, bt, ba, bd, fb);
    n_checks++; if (bt + ba + bd !== 0) begin n_fail++; $display("FAIL midrst_recover_tx: %0d/%0d/%0d bad cycles (first %0d) expected 0", bt, ba, bd, fb); end
    n_checks++; if (rx_data_out !== b) begin n_fail++; $display("FAIL midrst_recover_rx: got %h expected %h", rx_data_out, b); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_ignore_start();
    test_rx_errors();
    test_full_duplex();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
